// File: rtl/clock_hms_set_pkg.sv
// Shared types and BCD limits for the hh:mm:ss clock with button-driven time set.
// Also holds the 24h -> 12h display mapping used by the top.
package clock_hms_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        SET_H = 2'd1,
        SET_M = 2'd2
    } state_e;

    localparam int SEC_MAX  = 59;
    localparam int MIN_MAX  = 59;
    localparam int HOUR_MAX = 23;

    localparam logic [2:0] SEC_MAX_T  = 3'(SEC_MAX / 10);
    localparam logic [3:0] SEC_MAX_U  = 4'(SEC_MAX % 10);
    localparam logic [2:0] MIN_MAX_T  = 3'(MIN_MAX / 10);
    localparam logic [3:0] MIN_MAX_U  = 4'(MIN_MAX % 10);
    localparam logic [1:0] HOUR_MAX_T = 2'(HOUR_MAX / 10);
    localparam logic [3:0] HOUR_MAX_U = 4'(HOUR_MAX % 10);

    typedef struct packed {
        logic [1:0] t;
        logic [3:0] u;
    } hour_bcd_t;

    // Range is tiny (0..23), so compare/subtract replaces any BCD division.
    function automatic hour_bcd_t to_display(input logic [1:0] t, input logic [3:0] u,
                                             input logic h12);
        hour_bcd_t  r_res;
        logic [4:0] bin;
        logic [4:0] v;
        bin = {3'b000, t} * 5'd10 + {1'b0, u};
        if (bin == 5'd0)
            v = 5'd12;
        else if (bin > 5'd12)
            v = bin - 5'd12;
        else
            v = bin;
        if (!h12) begin
            r_res.t = t;
            r_res.u = u;
        end else if (v >= 5'd10) begin
            r_res.t = 2'd1;
            r_res.u = 4'(v - 5'd10);
        end else begin
            r_res.t = 2'd0;
            r_res.u = 4'(v);
        end
        return r_res;
    endfunction

endpackage

// File: rtl/clock_hms_set_if.sv
// Button inputs and BCD display outputs of the clock core, with driver/core modports.
interface clock_hms_set_if;
    logic       mode_p;
    logic       inc_p;
    logic       h12;
    logic [1:0] hour_t;
    logic [3:0] hour_u;
    logic [2:0] min_t;
    logic [3:0] min_u;
    logic [2:0] sec_t;
    logic [3:0] sec_u;
    logic       pm;
    logic [5:0] blank;
    logic       tick1hz;

    modport master (
        output mode_p, inc_p, h12,
        input  hour_t, hour_u, min_t, min_u, sec_t, sec_u, pm, blank, tick1hz
    );

    modport slave (
        input  mode_p, inc_p, h12,
        output hour_t, hour_u, min_t, min_u, sec_t, sec_u, pm, blank, tick1hz
    );
endinterface

// File: rtl/clock_hms_set_bcd_mod_cnt.sv
// Two-digit BCD modulo counter: counts 0..{max_t,max_u} then wraps to 0 with carry.
// load has priority over en; ca is combinational so carries ripple within one edge.
module bcd_mod_cnt #(
    parameter int               W_T   = 3,
    parameter logic [W_T-1:0]   RST_T = '0,
    parameter logic [3:0]       RST_U = 4'd0
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           en,
    input  logic           load,
    input  logic [W_T-1:0] din_t,
    input  logic [3:0]     din_u,
    input  logic [W_T-1:0] max_t,
    input  logic [3:0]     max_u,
    output logic [W_T-1:0] dout_t,
    output logic [3:0]     dout_u,
    output logic           ca
);
    logic [W_T-1:0] r_t;
    logic [3:0]     r_u;
    logic           w_at_max;

    assign w_at_max = (r_t == max_t) && (r_u == max_u);

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_t <= RST_T;
            r_u <= RST_U;
        end else if (load) begin
            r_t <= din_t;
            r_u <= din_u;
        end else if (en) begin
            if (w_at_max) begin
                r_t <= '0;
                r_u <= 4'd0;
            end else if (r_u == 4'd9) begin
                r_t <= r_t + 1'b1;
                r_u <= 4'd0;
            end else begin
                r_u <= r_u + 4'd1;
            end
        end
    end

    assign dout_t = r_t;
    assign dout_u = r_u;
    assign ca     = en && !load && w_at_max;
endmodule

// File: rtl/clock_hms_set.sv
// hh:mm:ss clock core: 1 Hz prescaler, RUN/SET_H/SET_M set FSM with field blinking,
// and 12/24h display mapping. Drives BCD digits plus a per-digit blank mask.
module clock_hms_set
    import clock_hms_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BLINK_DIV  = 2,
    parameter int RESET_HOUR = 0,
    parameter int RESET_MIN  = 0
) (
    input  logic           CLK,
    input  logic           RST,
    clock_hms_set_if.slave bus
);
    localparam int            PW          = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRESC_LAST  = PW'(CLK_HZ - 1);
    localparam int            BLINK_HALF  = (CLK_HZ / (2 * BLINK_DIV) > 0) ? CLK_HZ / (2 * BLINK_DIV) : 1;
    localparam int            BW          = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [BW-1:0] BLINK_LAST  = BW'(BLINK_HALF - 1);

    state_e        r_state;
    state_e        w_state_next;
    logic [PW-1:0] r_presc;
    logic          r_tick;
    logic [BW-1:0] r_blink_cnt;
    logic          r_phase;

    logic w_run, w_sel_h, w_sel_m, w_exit, w_inc_acc, w_inc_h, w_inc_m;
    logic w_sec_ca, w_min_ca, w_hour_ca_unused;
    logic [2:0] w_sec_t, w_min_t;
    logic [3:0] w_sec_u, w_min_u, w_hour_u;
    logic [1:0] w_hour_t;
    hour_bcd_t  w_disp;
    logic [5:0] w_blank;

    always_ff @(posedge CLK) begin
        if (!RST)
            r_state <= RUN;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (bus.mode_p) begin
            unique case (r_state)
                RUN:     w_state_next = SET_H;
                SET_H:   w_state_next = SET_M;
                SET_M:   w_state_next = RUN;
                default: w_state_next = RUN;
            endcase
        end
    end

    always_comb begin
        w_run     = (r_state == RUN);
        w_sel_h   = (r_state == SET_H);
        w_sel_m   = (r_state == SET_M);
        w_exit    = w_sel_m && bus.mode_p;
        // mode_p wins over a coincident inc_p; edits only count while setting
        w_inc_acc = bus.inc_p && !bus.mode_p && !w_run;
        w_inc_h   = w_inc_acc && w_sel_h;
        w_inc_m   = w_inc_acc && w_sel_m;
    end

    // Leaving SET_M restarts the second so the set time begins on a full second
    always_ff @(posedge CLK) begin
        if (!RST || w_exit) begin
            r_presc <= '0;
            r_tick  <= 1'b0;
        end else begin
            r_presc <= (r_presc == PRESC_LAST) ? '0 : r_presc + 1'b1;
            r_tick  <= (r_presc == PRESC_LAST);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
        end else if (w_inc_acc) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b1;
        end else if (r_blink_cnt == BLINK_LAST) begin
            r_blink_cnt <= '0;
            r_phase     <= !r_phase;
        end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
        end
    end

    bcd_mod_cnt #(.W_T(3), .RST_T(3'd0), .RST_U(4'd0)) u_sec (
        .CLK(CLK), .RST(RST), .en(w_run && r_tick), .load(w_exit),
        .din_t(3'd0), .din_u(4'd0), .max_t(SEC_MAX_T), .max_u(SEC_MAX_U),
        .dout_t(w_sec_t), .dout_u(w_sec_u), .ca(w_sec_ca)
    );

    bcd_mod_cnt #(.W_T(3), .RST_T(3'(RESET_MIN / 10)), .RST_U(4'(RESET_MIN % 10))) u_min (
        .CLK(CLK), .RST(RST), .en((w_run && w_sec_ca) || w_inc_m), .load(1'b0),
        .din_t(3'd0), .din_u(4'd0), .max_t(MIN_MAX_T), .max_u(MIN_MAX_U),
        .dout_t(w_min_t), .dout_u(w_min_u), .ca(w_min_ca)
    );

    // Minute carry is only a time carry in RUN; in SET_M it is an edit wrap
    bcd_mod_cnt #(.W_T(2), .RST_T(2'(RESET_HOUR / 10)), .RST_U(4'(RESET_HOUR % 10))) u_hour (
        .CLK(CLK), .RST(RST), .en((w_run && w_min_ca) || w_inc_h), .load(1'b0),
        .din_t(2'd0), .din_u(4'd0), .max_t(HOUR_MAX_T), .max_u(HOUR_MAX_U),
        .dout_t(w_hour_t), .dout_u(w_hour_u), .ca(w_hour_ca_unused)
    );

    always_comb begin
        w_disp  = to_display(w_hour_t, w_hour_u, bus.h12);
        w_blank = 6'b000000;
        if (w_sel_h && !r_phase)
            w_blank[5:4] = 2'b11;
        if (w_sel_m && !r_phase)
            w_blank[3:2] = 2'b11;
        if (bus.h12 && (w_disp.t == 2'd0))
            w_blank[5] = 1'b1;
    end

    assign bus.hour_t  = w_disp.t;
    assign bus.hour_u  = w_disp.u;
    assign bus.min_t   = w_min_t;
    assign bus.min_u   = w_min_u;
    assign bus.sec_t   = w_sec_t;
    assign bus.sec_u   = w_sec_u;
    assign bus.pm      = (w_hour_t == 2'd2) || ((w_hour_t == 2'd1) && (w_hour_u >= 4'd2));
    assign bus.blank   = w_blank;
    assign bus.tick1hz = r_tick;
endmodule

// File: tb/tb_clock_hms_set.sv
// Directed bench for clock_hms_set at CLK_HZ=10, BLINK_DIV=1 (tick every 10 cycles,
// blink phase every 5 cycles). Inputs change and outputs are sampled on the falling edge.
module tb_clock_hms_set;
    logic CLK = 1'b0;
    logic RST;
    int   n_checks = 0;
    int   n_errors = 0;

    clock_hms_set_if bus ();

    clock_hms_set #(.CLK_HZ(10), .BLINK_DIV(1), .RESET_HOUR(0), .RESET_MIN(0)) dut (
        .CLK(CLK), .RST(RST), .bus(bus)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end else begin
            $display("[chk] %s = %0d ok", tag, obs);
        end
    endtask

    function automatic int hh();
        return int'(bus.hour_t) * 10 + int'(bus.hour_u);
    endfunction
    function automatic int mm();
        return int'(bus.min_t) * 10 + int'(bus.min_u);
    endfunction
    function automatic int ss();
        return int'(bus.sec_t) * 10 + int'(bus.sec_u);
    endfunction

    task automatic pulse_mode();
        bus.mode_p = 1'b1;
        @(negedge CLK);
        bus.mode_p = 1'b0;
    endtask

    task automatic pulse_inc(input int n);
        for (int i = 0; i < n; i++) begin
            bus.inc_p = 1'b1;
            @(negedge CLK);
            bus.inc_p = 1'b0;
            @(negedge CLK);
        end
    endtask

    // From RUN: enter SET_H, add n to hour, pass through SET_M, back to RUN
    task automatic add_hours(input int n);
        pulse_mode();
        pulse_inc(n);
        pulse_mode();
        pulse_mode();
    endtask

    initial begin
        int ticks, last, bad, first, seen_on, seen_off, other;
        RST = 1'b0;
        bus.mode_p = 1'b0;
        bus.inc_p  = 1'b0;
        bus.h12    = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst_tick", bus.tick1hz, 0);
        chk("rst_blank", bus.blank, 0);
        chk("rst_time", hh() * 10000 + mm() * 100 + ss(), 0);
        chk("rst_pm", bus.pm, 0);
        RST = 1'b1;

        // 1: free run, tick every 10 cycles, 00:00:59 then 00:01:00
        ticks = 0; last = 0; bad = 0;
        for (int k = 1; k <= 601; k++) begin
            @(negedge CLK);
            if (k <= 600 && bus.tick1hz) begin
                ticks++;
                if (k - last != 10) bad++;
                last = k;
            end
            if (k == 595) chk("run_000059", hh() * 10000 + mm() * 100 + ss(), 59);
            if (k == 601) chk("run_000100", hh() * 10000 + mm() * 100 + ss(), 100);
        end
        chk("tick_count", ticks, 60);
        chk("tick_spacing_bad", bad, 0);

        // 2: preload 23:59 via set FSM, run 59 s, then midnight rollover
        pulse_mode();
        pulse_inc(23);
        chk("set_hour23", hh(), 23);
        chk("set_pm23", bus.pm, 1);
        pulse_mode();
        pulse_inc(58);
        chk("set_min59", mm(), 59);
        pulse_mode();
        chk("exit_sec_clr", ss(), 0);
        for (int k = 1; k <= 601; k++) begin
            @(negedge CLK);
            if (k == 591) begin
                chk("pre_midnight", hh() * 10000 + mm() * 100 + ss(), 235959);
                chk("pre_midnight_pm", bus.pm, 1);
            end
            if (k == 601) begin
                chk("midnight", hh() * 10000 + mm() * 100 + ss(), 0);
                chk("midnight_pm", bus.pm, 0);
            end
        end

        // 3: 25 hour increments wrap to 01; only hour digits blink
        pulse_mode();
        pulse_inc(25);
        chk("hour_wrap", hh(), 1);
        chk("min_sec_kept", mm() * 100 + ss(), 0);
        chk("blink_forced_on", bus.blank, 0);
        seen_on = 0; seen_off = 0; other = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge CLK);
            if (bus.blank[5:4] == 2'b11) seen_off = 1;
            if (bus.blank[5:4] == 2'b00) seen_on = 1;
            if (bus.blank[3:0] != 4'b0000) other = 1;
        end
        chk("hour_blank_seen", seen_off, 1);
        chk("hour_visible_seen", seen_on, 1);
        chk("other_blank", other, 0);

        // 4: mode_p wins over inc_p; next inc edits minutes
        bus.inc_p = 1'b1;
        pulse_mode();
        bus.inc_p = 1'b0;
        chk("mode_wins_hour", hh(), 1);
        pulse_inc(1);
        chk("in_set_m_min", mm(), 1);
        chk("in_set_m_hour", hh(), 1);

        // 6: reset while in SET_M mid-blink
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        chk("mid_rst_time", hh() * 10000 + mm() * 100 + ss(), 0);
        chk("mid_rst_blank", bus.blank, 0);
        chk("mid_rst_tick", bus.tick1hz, 0);
        first = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge CLK);
            if (bus.tick1hz && first == 0) first = k;
        end
        chk("rst_first_tick", first, 10);
        pulse_inc(1);
        chk("run_inc_ignored", hh() * 100 + mm(), 0);
        chk("run_blank", bus.blank, 0);

        // 5: 12-hour display at hours 0, 12, 13, 9
        bus.h12 = 1'b1;
        @(negedge CLK);
        chk("h12_h0", hh(), 12);
        chk("h12_h0_blank5", bus.blank[5], 0);
        chk("h12_h0_pm", bus.pm, 0);
        add_hours(12);
        chk("h12_h12", hh(), 12);
        chk("h12_h12_pm", bus.pm, 1);
        add_hours(1);
        chk("h12_h13", hh(), 1);
        chk("h12_h13_blank5", bus.blank[5], 1);
        chk("h12_h13_pm", bus.pm, 1);
        bus.h12 = 1'b0;
        @(negedge CLK);
        chk("h24_h13", hh(), 13);
        chk("h24_h13_blank", bus.blank, 0);
        bus.h12 = 1'b1;
        add_hours(20);
        chk("h12_h9", hh(), 9);
        chk("h12_h9_blank5", bus.blank[5], 1);
        chk("h12_h9_pm", bus.pm, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
